// File: rtl/mac_rx_pkg.sv
// Shared EtherType constants, broadcast MAC and dispatch FSM states.
package mac_rx_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;

  localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_SOF  = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

endpackage

// File: rtl/mac_rx_sat_cnt.sv
// Saturating statistics counter: increments on inc, holds at all-ones, synchronous reset.
module mac_rx_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mac_rx_dispatch.sv
// EtherType demultiplexer: routes each frame on its first beat to one of NUM_CH channels, 1-cycle registered.
// Optional destination-MAC filter enabled by MAC_RX_DST_FILTER_EN.
module mac_rx_dispatch
  import mac_rx_pkg::*;
#(
  parameter int                    DATA_W   = 64,
  parameter int                    NUM_CH   = 3,
  parameter logic [NUM_CH*16-1:0]  CH_TYPES = {ETH_TYPE_IPV6, ETH_TYPE_ARP, ETH_TYPE_IPV4},
  parameter int                    CNT_W    = 32,
  localparam int                   CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       rx_axis_aclk,
  input  logic                       rx_axis_reset,
  input  logic [DATA_W-1:0]          frame_rx_axis_tdata,
  input  logic [DATA_W/8-1:0]        frame_rx_axis_tkeep,
  input  logic                       frame_rx_axis_tvalid,
  input  logic                       frame_rx_axis_tlast,
  input  logic                       frame_rx_axis_tuser,
  input  logic [47:0]                rcvd_dst_mac_addr,
  input  logic [47:0]                rcvd_src_mac_addr,
  input  logic [15:0]                rcvd_type,
  input  logic [47:0]                local_mac_addr,
  output logic [NUM_CH*DATA_W-1:0]   ch_axis_tdata,
  output logic [NUM_CH*DATA_W/8-1:0] ch_axis_tkeep,
  output logic [NUM_CH-1:0]          ch_axis_tvalid,
  output logic [NUM_CH-1:0]          ch_axis_tlast,
  output logic [NUM_CH-1:0]          ch_axis_tuser,
  output logic [47:0]                frame_mode_dst_mac_addr,
  output logic [47:0]                frame_mode_src_mac_addr,
  output logic [CH_W-1:0]            frame_mode_ch,
  output logic [NUM_CH*CNT_W-1:0]    ch_frame_cnt,
  output logic [CNT_W-1:0]           drop_frame_cnt
);

  state_t            state, state_nxt;
  logic              type_hit;
  logic [CH_W-1:0]   type_idx;
  logic              dst_ok;
  logic              first_acc;
  logic              drop_new;
  logic [CH_W-1:0]   fwd_ch;
  logic [NUM_CH-1:0] sel;

`ifdef MAC_RX_DST_FILTER_EN
  assign dst_ok = (rcvd_dst_mac_addr == local_mac_addr) ||
                  (rcvd_dst_mac_addr == MAC_BROADCAST);
`else
  logic unused_local_mac;
  assign unused_local_mac = ^local_mac_addr;
  assign dst_ok = 1'b1;
`endif

  // Descending scan so the lowest matching index wins on duplicate table entries.
  always_comb begin
    type_hit = 1'b0;
    type_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rcvd_type == CH_TYPES[16*i +: 16]) begin
        type_hit = 1'b1;
        type_idx = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    first_acc = 1'b0;
    drop_new  = 1'b0;
    fwd_ch    = frame_mode_ch;
    sel       = '0;
    if (frame_rx_axis_tvalid) begin
      unique case (state)
        ST_SOF: begin
          if (type_hit && dst_ok) begin
            first_acc = 1'b1;
            fwd_ch    = type_idx;
            state_nxt = frame_rx_axis_tlast ? ST_SOF : ST_FWD;
          end else begin
            drop_new  = 1'b1;
            state_nxt = frame_rx_axis_tlast ? ST_SOF : ST_DROP;
          end
        end
        ST_FWD: begin
          if (frame_rx_axis_tlast) state_nxt = ST_SOF;
        end
        ST_DROP: begin
          if (frame_rx_axis_tlast) state_nxt = ST_SOF;
        end
        default: state_nxt = ST_SOF;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        sel[i] = (first_acc || (state == ST_FWD)) && (fwd_ch == CH_W'(i));
      end
    end
  end

  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_reset) begin
      state                   <= ST_SOF;
      ch_axis_tdata           <= '0;
      ch_axis_tkeep           <= '0;
      ch_axis_tvalid          <= '0;
      ch_axis_tlast           <= '0;
      ch_axis_tuser           <= '0;
      frame_mode_dst_mac_addr <= '0;
      frame_mode_src_mac_addr <= '0;
      frame_mode_ch           <= '0;
    end else begin
      state <= state_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_axis_tvalid[i]                         <= sel[i];
        ch_axis_tlast[i]                          <= sel[i] & frame_rx_axis_tlast;
        ch_axis_tuser[i]                          <= sel[i] & frame_rx_axis_tuser;
        ch_axis_tdata[i*DATA_W +: DATA_W]         <= sel[i] ? frame_rx_axis_tdata : '0;
        ch_axis_tkeep[i*(DATA_W/8) +: DATA_W/8]   <= sel[i] ? frame_rx_axis_tkeep : '0;
      end
      if (first_acc) begin
        frame_mode_dst_mac_addr <= rcvd_dst_mac_addr;
        frame_mode_src_mac_addr <= rcvd_src_mac_addr;
        frame_mode_ch           <= type_idx;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_cnt
    mac_rx_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk (rx_axis_aclk),
      .rst (rx_axis_reset),
      .inc (sel[g] & frame_rx_axis_tlast),
      .cnt (ch_frame_cnt[g*CNT_W +: CNT_W])
    );
  end

  mac_rx_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk (rx_axis_aclk),
    .rst (rx_axis_reset),
    .inc (drop_new),
    .cnt (drop_frame_cnt)
  );

endmodule

// File: tb/tb_mac_rx_dispatch.sv
// Directed bench for mac_rx_dispatch: routing, drops, back-to-back, reset mid-frame, optional dst filter.
module tb_mac_rx_dispatch;

  localparam int DW = 64;
  localparam int NC = 3;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tvalid, tlast, tuser;
  logic [47:0]     dst, src, lmac;
  logic [15:0]     ty;
  logic [NC*DW-1:0]   o_tdata;
  logic [NC*DW/8-1:0] o_tkeep;
  logic [NC-1:0]      o_tvalid, o_tlast, o_tuser;
  logic [47:0]        fm_dst, fm_src;
  logic [1:0]         fm_ch;
  logic [NC*CW-1:0]   ch_cnt;
  logic [CW-1:0]      drop_cnt;

  int vectors_applied = 0;
  int miscompares     = 0;

  always #5 clk = ~clk;

  mac_rx_dispatch dut (
    .rx_axis_aclk            (clk),
    .rx_axis_reset           (rst),
    .frame_rx_axis_tdata     (tdata),
    .frame_rx_axis_tkeep     (tkeep),
    .frame_rx_axis_tvalid    (tvalid),
    .frame_rx_axis_tlast     (tlast),
    .frame_rx_axis_tuser     (tuser),
    .rcvd_dst_mac_addr       (dst),
    .rcvd_src_mac_addr       (src),
    .rcvd_type               (ty),
    .local_mac_addr          (lmac),
    .ch_axis_tdata           (o_tdata),
    .ch_axis_tkeep           (o_tkeep),
    .ch_axis_tvalid          (o_tvalid),
    .ch_axis_tlast           (o_tlast),
    .ch_axis_tuser           (o_tuser),
    .frame_mode_dst_mac_addr (fm_dst),
    .frame_mode_src_mac_addr (fm_src),
    .frame_mode_ch           (fm_ch),
    .ch_frame_cnt            (ch_cnt),
    .drop_frame_cnt          (drop_cnt)
  );

  task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drives one beat, advances one edge, then checks the registered output for that beat.
  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u,
                      input logic [15:0] t, input int exp_ch);
    logic [191:0] ed, ek;
    logic [2:0]   ev, el, eu;
    tdata = d; tkeep = k; tlast = l; tuser = u; ty = t; tvalid = 1'b1;
    @(posedge clk); #1;
    ed = '0; ek = '0; ev = '0; el = '0; eu = '0;
    if (exp_ch >= 0) begin
      ed = {128'b0, d} << (64 * exp_ch);
      ek = {184'b0, k} << (8 * exp_ch);
      ev[exp_ch] = 1'b1;
      el[exp_ch] = l;
      eu[exp_ch] = u;
    end
    check("tvalid", {189'b0, o_tvalid}, {189'b0, ev});
    check("tdata",  o_tdata, ed);
    check("tkeep",  {168'b0, o_tkeep}, ek);
    check("tlast_tuser", {186'b0, o_tlast, o_tuser}, {186'b0, el, eu});
  endtask

  task automatic idle();
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = '0; tkeep = '0;
    @(posedge clk); #1;
    check("idle_tvalid", {189'b0, o_tvalid}, 192'd0);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] c0, input logic [31:0] c1,
                         input logic [31:0] c2, input logic [31:0] dr);
    check({tag, "_ch_cnt"}, {96'b0, ch_cnt}, {96'b0, c2, c1, c0});
    check({tag, "_drop"}, {160'b0, drop_cnt}, {160'b0, dr});
  endtask

  initial begin
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    tdata = '0; tkeep = '0; ty = '0; dst = '0; src = '0;
    lmac = 48'h000A_3501_0203;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {o_tdata[63:0], 5'b0, o_tvalid, o_tlast, o_tuser[0]}, 192'd0);
    check("rst_frame_mode", {94'b0, fm_dst, fm_src, fm_ch}, 192'd0);
    chk_cnt("rst", 0, 0, 0, 0);
    rst = 1'b0;
    idle();

    // 1: IPv4 3 beats then ARP 2 beats back-to-back
    dst = 48'h1111_2222_3333; src = 48'h4444_5555_6666;
    beat(64'hA0A0_0000_0000_0001, 8'hFF, 0, 0, 16'h0800, 0);
    check("t1_fm", {94'b0, fm_dst, fm_src, fm_ch}, {94'b0, 48'h1111_2222_3333, 48'h4444_5555_6666, 2'd0});
    beat(64'hA0A0_0000_0000_0002, 8'hFF, 0, 1, 16'h0800, 0);
    beat(64'hA0A0_0000_0000_0003, 8'h0F, 1, 0, 16'h0800, 0);
    dst = 48'h0102_0304_0506; src = 48'h0A0B_0C0D_0E0F;
    beat(64'hB0B0_0000_0000_0001, 8'hFF, 0, 0, 16'h0806, 1);
    check("t1_fm_arp", {189'b0, 1'b0, fm_ch}, {189'b0, 1'b0, 2'd1});
    beat(64'hB0B0_0000_0000_0002, 8'h03, 1, 0, 16'h0806, 1);
    idle();
    chk_cnt("t1", 1, 1, 0, 0);

    // 2: type changes after the first beat are ignored
    dst = 48'h2222_2222_2222; src = 48'h3333_3333_3333;
    beat(64'hC0C0_0000_0000_0001, 8'hFF, 0, 0, 16'h0800, 0);
    beat(64'hC0C0_0000_0000_0002, 8'hFF, 0, 0, 16'h0806, 0);
    beat(64'hC0C0_0000_0000_0003, 8'hFF, 0, 0, 16'h0806, 0);
    beat(64'hC0C0_0000_0000_0004, 8'hFF, 1, 0, 16'h0806, 0);
    idle();
    chk_cnt("t2", 2, 1, 0, 0);

    // 3: unknown EtherType dropped; frame_mode holds previous frame
    dst = 48'h9999_9999_9999; src = 48'h8888_8888_8888;
    for (int i = 0; i < 5; i++) beat(64'hD0D0_0000_0000_0000 + 64'(i), 8'hFF, i == 4, 0, 16'h88CC, -1);
    idle();
    chk_cnt("t3", 2, 1, 0, 1);
    check("t3_fm", {94'b0, fm_dst, fm_src, fm_ch}, {94'b0, 48'h2222_2222_2222, 48'h3333_3333_3333, 2'd0});

    // 4: single-beat IPv6 then IPv4 immediately after
    beat(64'hE0E0_0000_0000_0001, 8'h01, 1, 1, 16'h86DD, 2);
    check("t4_fm_ch", {190'b0, fm_ch}, {190'b0, 2'd2});
    beat(64'hE1E1_0000_0000_0001, 8'hFF, 0, 0, 16'h0800, 0);
    beat(64'hE1E1_0000_0000_0002, 8'hFF, 1, 0, 16'h0800, 0);
    idle();
    chk_cnt("t4", 3, 1, 1, 1);

    // 5: reset on beat 2 of a 4-beat frame
    beat(64'hF0F0_0000_0000_0001, 8'hFF, 0, 0, 16'h0800, 0);
    rst = 1'b1;
    beat(64'hF0F0_0000_0000_0002, 8'hFF, 0, 0, 16'h0800, -1);
    chk_cnt("t5_rst", 0, 0, 0, 0);
    check("t5_fm", {189'b0, 1'b0, fm_ch}, 192'd0);
    rst = 1'b0;
    beat(64'hF0F0_0000_0000_0003, 8'hFF, 0, 0, 16'h0806, 1);
    beat(64'hF0F0_0000_0000_0004, 8'hFF, 1, 0, 16'h0806, 1);
    idle();
    chk_cnt("t5", 0, 1, 0, 0);

    // 6: destination filter (broadcast accepted; other station dropped when enabled)
    dst = 48'hFFFF_FFFF_FFFF;
    beat(64'h6060_0000_0000_0001, 8'hFF, 0, 0, 16'h0806, 1);
    beat(64'h6060_0000_0000_0002, 8'hFF, 1, 0, 16'h0806, 1);
    dst = 48'h000A_3501_0204;
`ifdef MAC_RX_DST_FILTER_EN
    beat(64'h6161_0000_0000_0001, 8'hFF, 0, 0, 16'h0800, -1);
    beat(64'h6161_0000_0000_0002, 8'hFF, 1, 0, 16'h0800, -1);
    idle();
    chk_cnt("t6", 0, 2, 0, 1);
`else
    beat(64'h6161_0000_0000_0001, 8'hFF, 0, 0, 16'h0800, 0);
    beat(64'h6161_0000_0000_0002, 8'hFF, 1, 0, 16'h0800, 0);
    idle();
    chk_cnt("t6", 1, 2, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_rx_dispatch.md
Name: mac_rx_dispatch

Overview:
Frame-level EtherType demultiplexer between the MAC frame-RX parser and the per-protocol RX engines (IPv4, ARP, IPv6, ...).
- Generalises the fixed two-way IP/ARP split to NUM_CH channels with a parametrised EtherType table.
- Routes each frame on its first beat and holds that route to tlast.
- Latches per-frame MAC addresses and keeps saturating per-channel frame and drop counters.

Parameters:
DATA_W, 64, AXIS data width in bits (multiple of 8).
NUM_CH, 3, number of output channels.
CH_TYPES, {16'h86DD,16'h0806,16'h0800}, NUM_CH*16 packed EtherType table; channel i matches bits [16i+15:16i].
CNT_W, 32, width of each statistics counter.

Ports:
rx_axis_aclk  in  1  clock
rx_axis_reset  in  1  synchronous active-high reset
frame_rx_axis_tdata  in  DATA_W  input frame data
frame_rx_axis_tkeep  in  DATA_W/8  byte enables
frame_rx_axis_tvalid  in  1  beat valid (no backpressure)
frame_rx_axis_tlast  in  1  last beat of frame
frame_rx_axis_tuser  in  1  frame error flag
rcvd_dst_mac_addr  in  48  destination MAC; valid on the first beat
rcvd_src_mac_addr  in  48  source MAC; valid on the first beat
rcvd_type  in  16  EtherType; valid on the first beat
local_mac_addr  in  48  station MAC; used only with the optional feature
ch_axis_tdata  out  NUM_CH*DATA_W  per-channel data
ch_axis_tkeep  out  NUM_CH*DATA_W/8  per-channel keep
ch_axis_tvalid  out  NUM_CH  per-channel valid
ch_axis_tlast  out  NUM_CH  per-channel last
ch_axis_tuser  out  NUM_CH  per-channel error
frame_mode_dst_mac_addr  out  48  destination MAC of the frame being forwarded
frame_mode_src_mac_addr  out  48  source MAC of the frame being forwarded
frame_mode_ch  out  clog2(NUM_CH)  channel index of the frame being forwarded
ch_frame_cnt  out  NUM_CH*CNT_W  frames forwarded per channel
drop_frame_cnt  out  CNT_W  frames dropped

Behaviour:
- Reset: every output is 0 and the FSM enters SOF.
  - The first valid beat after reset is treated as a start of frame.
  - Upstream is reset concurrently.
- FSM states: SOF (awaiting first beat), FWD (forwarding), DROP (discarding).
- SOF with tvalid:
  - Compare rcvd_type against all CH_TYPES entries; on duplicate entries the lowest index wins.
  - Match: latch channel index, dst MAC and src MAC. Go to FWD, unless tlast is also set (single-beat frame), in which case stay in SOF.
  - No match: go to DROP, or stay in SOF on a single-beat frame.
- FWD: each valid beat goes to the latched channel; tlast returns the FSM to SOF.
- DROP: beats are discarded; tlast returns the FSM to SOF.
- rcvd_type is ignored outside the first beat.
- Output stage:
  - Fully registered; latency 1 cycle from input beat to ch_axis_* beat.
  - tdata/tkeep/tlast/tuser are driven only on the selected channel. Non-selected channels hold tvalid=0 and zeroed data/keep/last/user.
  - A cycle with input tvalid=0 produces tvalid=0 on all channels.
- frame_mode_* update in the same cycle as the first output beat and hold until the next accepted frame's first beat.
- Counters:
  - ch_frame_cnt[i] increments on the output tlast beat of channel i.
  - drop_frame_cnt increments when a dropped frame is decided (on its first beat).
  - Counters saturate at all-ones.
  - tuser does not affect counting or routing; it is passed through.
- Back-to-back frames with no idle cycle (tlast followed immediately by a new first beat) must route correctly.
- Reset asserted mid-frame: outputs clear the next cycle. The partial frame emits no tlast, and counters clear.

Optional Feature:
Macro MAC_RX_DST_FILTER_EN.
- Defined: in SOF, a frame is accepted only if rcvd_dst_mac_addr equals local_mac_addr or 48'hFFFF_FFFF_FFFF. Any other destination goes to DROP and increments drop_frame_cnt, even when the EtherType matches.
- Undefined: local_mac_addr is ignored and routing depends on EtherType only.

Decomposition:
- Shared package mac_rx_pkg holds:
  - the EtherType constants ETH_TYPE_IPV4=16'h0800, ETH_TYPE_ARP=16'h0806, ETH_TYPE_IPV6=16'h86DD;
  - the broadcast MAC constant;
  - the FSM state enum {ST_SOF, ST_FWD, ST_DROP}.
- One natural sub-module, mac_rx_sat_cnt: a parametrised CNT_W saturating counter with increment and synchronous reset, instantiated NUM_CH+1 times.

Test Plan:
1. IPv4 3-beat frame, rcvd_type=0800, then an ARP 2-beat frame back-to-back.
   - Channel 0 sees 3 beats with tlast on beat 3, each 1 cycle later than the input.
   - Channel 1 sees 2 beats.
   - ch_frame_cnt = {0,1,1}.
2. Frame with rcvd_type=0800 on beat 1 and rcvd_type changed to 0806 on beats 2-4.
   - All 4 beats appear on channel 0; channel 1 tvalid stays 0.
3. rcvd_type=88CC, 5 beats.
   - No output tvalid on any channel; drop_frame_cnt=1; frame_mode_* retain the previous frame's values.
4. Single-beat IPv6 frame (tvalid&tlast, rcvd_type=86DD), then an IPv4 frame the next cycle.
   - Channel 2 gets 1 beat with tlast; channel 0 gets the following frame.
5. Reset asserted on beat 2 of a 4-beat frame.
   - All outputs are 0 the next cycle and counters are 0.
   - The next valid beat is treated as a start of frame and routed by its rcvd_type.
6. With MAC_RX_DST_FILTER_EN, local_mac_addr=00_0A_35_01_02_03:
   - dst=FF..FF ARP frame is forwarded.
   - dst=00_0A_35_01_02_04 IPv4 frame is dropped with drop_frame_cnt=1.
   - Without the macro, both frames are forwarded.
